// File: rtl/uart_rx_fifo_if.sv
// Interface bundling the receiver-facing and consumer-facing signals of
// uart_rx_fifo. Clock and reset stay as plain module ports.
//   RxDone, RxData : frame strobe and byte from the UART receiver
//   RdEn, ClrOvr   : pop request and overrun-clear from the consumer
//   RdData, RdValid: popped/head byte and its qualifier
//   Empty, Full, Count, Overrun : occupancy and sticky drop flag
// Modport slave is taken by the FIFO, master by whatever drives it.
interface uart_rx_fifo_if #(
  parameter int unsigned AW = 4
);
  logic          RxDone;
  logic [7:0]    RxData;
  logic          RdEn;
  logic          ClrOvr;
  logic [7:0]    RdData;
  logic          RdValid;
  logic          Empty;
  logic          Full;
  logic [AW:0]   Count;
  logic          Overrun;

  modport slave (
    input  RxDone, RxData, RdEn, ClrOvr,
    output RdData, RdValid, Empty, Full, Count, Overrun
  );

  modport master (
    output RxDone, RxData, RdEn, ClrOvr,
    input  RdData, RdValid, Empty, Full, Count, Overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO sitting behind the UART receiver. Each rising edge
// of RxDone (after a two-flop synchronizer) writes RxData into a circular
// buffer of DEPTH bytes; the consumer pops through RdEn. Occupancy is
// reported through Count/Empty/Full, and Overrun latches when a frame is
// dropped because the buffer was full (cleared by ClrOvr).
// Ports:
//   Clk   : system clock, rising edge
//   Rst_n : synchronous reset, active HIGH (name kept from the receiver)
//   bus   : uart_rx_fifo_if.slave (RxDone, RxData, RdEn, ClrOvr in;
//           RdData, RdValid, Empty, Full, Count, Overrun out)
// Build option:
//   UART_RX_FIFO_FWFT_EN defined  -> first-word-fall-through: RdData shows
//                                    the head entry, RdValid = ~Empty
//   UART_RX_FIFO_FWFT_EN undefined-> registered read, 1-cycle latency
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input logic           Clk,
  input logic           Rst_n,
  uart_rx_fifo_if.slave bus
);

  logic          s1, s2, p;
  logic          wr;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wptr, rptr, count;
  logic          empty, full;
  logic          rd_acc, wr_acc, drop;
  logic          overrun;

  // Synchronizer plus edge-detect flop. Resetting all three to 1 means an
  // RxDone already high when reset releases looks like "no edge".
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      p  <= 1'b1;
    end else begin
      s1 <= bus.RxDone;
      s2 <= s1;
      p  <= s2;
    end
  end

  always_comb begin
    wr     = s2 & ~p;
    empty  = (count == '0);
    full   = (count == (AW+1)'(DEPTH));
    rd_acc = bus.RdEn & ~empty;
    // A read in the same cycle frees the slot the write needs.
    wr_acc = wr & (~full | rd_acc);
    drop   = wr & full & ~rd_acc;
  end

  always_ff @(posedge Clk) begin
    if (wr_acc) begin
      mem[wptr[AW-1:0]] <= bus.RxData;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (rd_acc) begin
        rptr <= rptr + (AW+1)'(1);
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // A new drop wins over a simultaneous clear.
      if (drop) begin
        overrun <= 1'b1;
      end else if (bus.ClrOvr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_FWFT_EN
  always_comb begin
    bus.RdData  = mem[rptr[AW-1:0]];
    bus.RdValid = ~empty;
  end
`else
  logic [7:0] rd_data;
  logic       rd_valid;

  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rptr[AW-1:0]];
      end
    end
  end

  always_comb begin
    bus.RdData  = rd_data;
    bus.RdValid = rd_valid;
  end
`endif

  always_comb begin
    bus.Empty   = empty;
    bus.Full    = full;
    bus.Count   = count;
    bus.Overrun = overrun;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo (either read mode, selected by UART_RX_FIFO_FWFT_EN).
// A queue-based reference model tracks buffered bytes, occupancy and the
// overrun flag from the receiver-side rules; a negedge monitor compares the
// DUT against it every cycle and pops read results from a scoreboard queue.
module tb_uart_rx_fifo;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic Clk;
  logic Rst_n;
  logic rd_dir;
  logic rd_rand;
  logic rd_rand_en;
  int unsigned rd_pct;
  logic mon_on;

  int checks;
  int failures;

  uart_rx_fifo_if #(.AW(AW)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  assign bus.RdEn = rd_dir | rd_rand;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model state
  logic [7:0] ref_q [$];
  logic       ovr;
  logic       last_d, rise1, rise2;
`ifndef UART_RX_FIFO_FWFT_EN
  logic [7:0] exp_q [$];
  logic [7:0] last_rd;
  logic       rv_exp;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a rising edge of RxDone as seen at a clock edge; its
  // byte lands in the buffer two edges later. Reads pop the head.
  initial begin
    logic commit, rd, drop, full_now;
    logic [7:0] b;
    ovr = 1'b0; last_d = 1'b1; rise1 = 1'b0; rise2 = 1'b0;
`ifndef UART_RX_FIFO_FWFT_EN
    last_rd = 8'h00; rv_exp = 1'b0;
`endif
    forever begin
      @(posedge Clk);
      if (Rst_n) begin
        ref_q.delete();
        ovr = 1'b0; last_d = 1'b1; rise1 = 1'b0; rise2 = 1'b0;
`ifndef UART_RX_FIFO_FWFT_EN
        exp_q.delete(); last_rd = 8'h00; rv_exp = 1'b0;
`endif
      end else begin
        commit   = rise2;
        rise2    = rise1;
        rise1    = bus.RxDone && !last_d;
        last_d   = bus.RxDone;
        rd       = bus.RdEn && (ref_q.size() != 0);
        full_now = (ref_q.size() == DEPTH);
        drop     = commit && full_now && !rd;
        if (rd) begin
          b = ref_q.pop_front();
`ifndef UART_RX_FIFO_FWFT_EN
          exp_q.push_back(b);
          last_rd = b;
`endif
        end
`ifndef UART_RX_FIFO_FWFT_EN
        rv_exp = rd;
`endif
        if (commit && !drop) ref_q.push_back(bus.RxData);
        if (drop) ovr = 1'b1;
        else if (bus.ClrOvr) ovr = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge Clk);
      if (mon_on) begin
        chk("count", int'(bus.Count), ref_q.size());
        chk("empty", int'(bus.Empty), int'(ref_q.size() == 0));
        chk("full", int'(bus.Full), int'(ref_q.size() == DEPTH));
        chk("overrun", int'(bus.Overrun), int'(ovr));
`ifdef UART_RX_FIFO_FWFT_EN
        chk("rd_valid", int'(bus.RdValid), int'(ref_q.size() != 0));
        if (ref_q.size() != 0) chk("head", int'(bus.RdData), int'(ref_q[0]));
`else
        chk("rd_valid", int'(bus.RdValid), int'(rv_exp));
        if (bus.RdValid) begin
          if (exp_q.size() == 0) begin
            chk("rd_unexpected", int'(bus.RdValid), 0);
          end else begin
            e = exp_q.pop_front();
            chk("rd_data", int'(bus.RdData), int'(e));
          end
        end
        chk("rd_hold", int'(bus.RdData), int'(last_rd));
`endif
      end
    end
  end

  // Random reader
  initial begin
    rd_rand = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      rd_rand = rd_rand_en && ($urandom_range(0, 99) < rd_pct);
    end
  end

  initial begin
    #1ms;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Tasks are entered 1 time unit after a rising edge.
  task automatic send_frame(input logic [7:0] b, input int unsigned hold, input int unsigned gap);
    bus.RxData = b;
    bus.RxDone = 1'b1;
    repeat (hold) @(posedge Clk);
    #1;
    bus.RxDone = 1'b0;
    repeat (gap) @(posedge Clk);
    #1;
  endtask

  // Drives RdEn/ClrOvr on exactly the edge where the frame's write commits.
  task automatic frame_at_commit(input logic [7:0] b, input logic rd, input logic clr);
    bus.RxData = b;
    bus.RxDone = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    rd_dir = rd;
    bus.ClrOvr = clr;
    @(posedge Clk);
    #1;
    rd_dir = 1'b0;
    bus.ClrOvr = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    bus.RxDone = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    rd_dir = 1'b1;
    while (ref_q.size() != 0 && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
    end
    rd_dir = 1'b0;
    @(posedge Clk);
    #1;
    chk("drain_within_budget", int'(n < 100), 1);
  endtask

  task automatic pulse_clr();
    bus.ClrOvr = 1'b1;
    @(posedge Clk);
    #1;
    bus.ClrOvr = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    mon_on = 1'b0; rd_dir = 1'b0; rd_rand_en = 1'b0; rd_pct = 0;
    bus.RxDone = 1'b0; bus.RxData = 8'h00; bus.ClrOvr = 1'b0;
    Rst_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    mon_on = 1'b1;
    chk("reset_count", int'(bus.Count), 0);
    chk("reset_empty", int'(bus.Empty), 1);
    chk("reset_full", int'(bus.Full), 0);
    chk("reset_overrun", int'(bus.Overrun), 0);
    chk("reset_rd_valid", int'(bus.RdValid), 0);
`ifndef UART_RX_FIFO_FWFT_EN
    chk("reset_rd_data", int'(bus.RdData), 0);
`endif
    repeat (2) @(posedge Clk);
    #1;

    // Single byte, long strobe
    bus.RxData = 8'hA5;
    bus.RxDone = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk("single_count_before_commit", int'(bus.Count), 0);
    @(posedge Clk);
    #1;
    chk("single_count_after_commit", int'(bus.Count), 1);
    chk("single_empty_after_commit", int'(bus.Empty), 0);
    repeat (37) @(posedge Clk);
    #1;
    bus.RxDone = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    chk("single_one_write", int'(bus.Count), 1);
`ifdef UART_RX_FIFO_FWFT_EN
    chk("single_fwft_head", int'(bus.RdData), 8'hA5);
    chk("single_fwft_valid", int'(bus.RdValid), 1);
`endif
    rd_dir = 1'b1;
    @(posedge Clk);
    #1;
    rd_dir = 1'b0;
`ifndef UART_RX_FIFO_FWFT_EN
    chk("single_rd_valid", int'(bus.RdValid), 1);
    chk("single_rd_data", int'(bus.RdData), 8'hA5);
`endif
    chk("single_empty_after_read", int'(bus.Empty), 1);
    @(posedge Clk);
    #1;
    chk("single_rd_valid_one_cycle", int'(bus.RdValid), 0);

    // Fill, overflow, clear
    for (int i = 0; i < 16; i++) send_frame(8'(i), 3, 5);
    chk("fill_full", int'(bus.Full), 1);
    chk("fill_count", int'(bus.Count), 16);
    chk("fill_no_overrun", int'(bus.Overrun), 0);
    send_frame(8'h10, 3, 5);
    chk("overflow_overrun", int'(bus.Overrun), 1);
    chk("overflow_count", int'(bus.Count), 16);
    pulse_clr();
    chk("clr_overrun", int'(bus.Overrun), 0);
    frame_at_commit(8'h66, 1'b0, 1'b1);
    chk("clr_vs_new_overrun", int'(bus.Overrun), 1);
    pulse_clr();

    // Simultaneous read and write at full
    frame_at_commit(8'h55, 1'b1, 1'b0);
    chk("full_rw_count", int'(bus.Count), 16);
    chk("full_rw_overrun", int'(bus.Overrun), 0);
    drain();
`ifndef UART_RX_FIFO_FWFT_EN
    chk("full_rw_last_byte", int'(bus.RdData), 8'h55);
`endif

    // Wrap-around with interleaved reads, then reads while empty
    rd_rand_en = 1'b1;
    rd_pct = 60;
    for (int i = 0; i < 40; i++) send_frame(8'(8'h30 + i), $urandom_range(1, 6), $urandom_range(4, 8));
    rd_rand_en = 1'b0;
    drain();
    rd_dir = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    rd_dir = 1'b0;
    chk("empty_read_count", int'(bus.Count), 0);
    chk("empty_read_rd_valid", int'(bus.RdValid), 0);

    // Reset mid-stream with RxDone held high
    for (int i = 0; i < 4; i++) send_frame(8'(8'h40 + i), 2, 5);
    bus.RxData = 8'h44;
    bus.RxDone = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    chk("pre_reset_count", int'(bus.Count), 5);
    Rst_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    chk("mid_reset_count", int'(bus.Count), 0);
    chk("mid_reset_empty", int'(bus.Empty), 1);
`ifndef UART_RX_FIFO_FWFT_EN
    chk("mid_reset_rd_data", int'(bus.RdData), 0);
`endif
    repeat (10) @(posedge Clk);
    #1;
    chk("held_rxdone_no_write", int'(bus.Count), 0);
    bus.RxDone = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    send_frame(8'h77, 3, 5);
    chk("post_reset_write", int'(bus.Count), 1);
    drain();

    // Randomized traffic
    rd_rand_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      rd_pct = (i < 50) ? 10 : ((i < 100) ? 50 : 90);
      if ($urandom_range(0, 7) == 0) pulse_clr();
      send_frame(8'($urandom), $urandom_range(1, 20), $urandom_range(4, 12));
    end
    rd_rand_en = 1'b0;
    drain();

`ifndef UART_RX_FIFO_FWFT_EN
    chk("scoreboard_empty", exp_q.size(), 0);
`endif
    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
